// File: rtl/life_frame_loader_if.sv
// Row-stream handshake between a board source and the frame loader.
// One beat carries one COLS-bit board row plus an end-of-frame flag.
interface life_frame_loader_if #(
    parameter int COLS = 16
);
    logic            row_valid;
    logic [COLS-1:0] row_data;
    logic            row_last;
    logic            row_ready;

    modport master (
        output row_valid,
        output row_data,
        output row_last,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_data,
        input  row_last,
        output row_ready
    );
endinterface

// File: rtl/life_frame_loader.sv
// Writer side of the life engine load path: assembles row beats into a
// private buffer and publishes only complete, correctly framed boards.
module life_frame_loader #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    life_frame_loader_if.slave   row,
    input  logic                 abort,
    output logic [ROWS*COLS-1:0] frame_data,
    output logic                 load,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     frames_loaded
);
    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [RW-1:0]         row_cnt, row_cnt_d;
    logic [ROWS*COLS-1:0]  build, build_nx;
    logic                  store;
    logic                  commit;
    logic                  err_d;
    logic                  accept;

    assign row.row_ready = !reset && (state != COMMIT);
    assign busy          = (state != IDLE);
    assign accept        = row.row_valid && row.row_ready;

    // Next-state decode; abort wins over any beat in IDLE/FILL.
    always_comb begin
        state_d   = state;
        row_cnt_d = row_cnt;
        store     = 1'b0;
        commit    = 1'b0;
        err_d     = 1'b0;
        unique case (state)
            IDLE: begin
                row_cnt_d = '0;
                if (!abort && accept) begin
                    if (row.row_last) begin
                        err_d = 1'b1;
                    end else begin
                        store     = 1'b1;
                        row_cnt_d = RW'(1);
                        state_d   = FILL;
                    end
                end
            end
            FILL: begin
                if (abort) begin
                    state_d   = IDLE;
                    row_cnt_d = '0;
                end else if (accept) begin
                    if (row_cnt == LAST_ROW) begin
                        if (row.row_last) begin
                            store   = 1'b1;
                            commit  = 1'b1;
                            state_d = COMMIT;
                        end else begin
                            err_d     = 1'b1;
                            state_d   = IDLE;
                            row_cnt_d = '0;
                        end
                    end else if (row.row_last) begin
                        err_d     = 1'b1;
                        state_d   = IDLE;
                        row_cnt_d = '0;
                    end else begin
                        store     = 1'b1;
                        row_cnt_d = row_cnt + RW'(1);
                    end
                end
            end
            COMMIT: begin
                state_d   = IDLE;
                row_cnt_d = '0;
            end
            default: begin
                state_d   = IDLE;
                row_cnt_d = '0;
            end
        endcase
    end

    // Build buffer with the current beat merged into its row slot.
    always_comb begin
        build_nx = build;
        for (int r = 0; r < ROWS; r++) begin
            if (store && (row_cnt == RW'(r))) begin
                build_nx[r*COLS +: COLS] = row.row_data;
            end
        end
    end

    // FSM state and row counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            row_cnt <= '0;
        end else begin
            state   <= state_d;
            row_cnt <= row_cnt_d;
        end
    end

    // Datapath: buffer, published frame, pulses and commit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            build         <= '0;
            frame_data    <= '0;
            load          <= 1'b0;
            err           <= 1'b0;
            frames_loaded <= '0;
        end else begin
            build <= build_nx;
            if (commit) begin
                frame_data <= build_nx;
            end
            load <= commit;
            err  <= err_d;
            if (state == COMMIT) begin
                frames_loaded <= frames_loaded + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_life_frame_loader.sv
// Directed bench for life_frame_loader: framing, gaps, errors, abort,
// mid-frame reset and frame counter wrap.
module tb_life_frame_loader;
    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int W    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset;
    logic          abort;
    logic [W-1:0]  frame_data;
    logic          load;
    logic          busy;
    logic          err;
    logic [7:0]    frames_loaded;

    int errors = 0;
    int checks = 0;
    int load_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int last_load = -1000;

    life_frame_loader_if #(.COLS(COLS)) rif ();

    life_frame_loader #(
        .ROWS (ROWS),
        .COLS (COLS),
        .CNT_W(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .row          (rif.slave),
        .abort        (abort),
        .frame_data   (frame_data),
        .load         (load),
        .busy         (busy),
        .err          (err),
        .frames_loaded(frames_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (load === 1'b1) begin
            load_cnt++;
            chk("ready_low_in_commit", W'(rif.row_ready), W'(0));
            chk("load_spacing_ge17", W'((cyc - last_load) >= 17), W'(1));
            chk("no_err_with_load", W'(err), W'(0));
            last_load = cyc;
        end
        if (err === 1'b1) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [COLS-1:0] d, input logic l);
        int n;
        n = 0;
        rif.row_valid = 1'b1;
        rif.row_data  = d;
        rif.row_last  = l;
        while (rif.row_ready !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        chk("ready_wait", W'(rif.row_ready), W'(1));
        tick(1);
        rif.row_valid = 1'b0;
        rif.row_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] f, input bit gaps);
        for (int r = 0; r < ROWS; r++) begin
            send_beat(f[r*COLS +: COLS], r == ROWS - 1);
            if (gaps && r < ROWS - 1) tick((r % 3) + 1);
        end
    endtask

    task automatic check_commit(input string tag, input logic [W-1:0] f);
        chk({tag, "_load"}, W'(load), W'(1));
        chk({tag, "_ready0"}, W'(rif.row_ready), W'(0));
        chk({tag, "_busy"}, W'(busy), W'(1));
        chk({tag, "_data"}, frame_data, f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] diag, anti, glider, wf;
        diag   = '0;
        anti   = '0;
        glider = '0;
        for (int r = 0; r < ROWS; r++) begin
            diag[r*COLS + r]        = 1'b1;
            anti[r*COLS + 15 - r]   = 1'b1;
        end
        glider[0*COLS +: COLS] = 16'h0002;
        glider[1*COLS +: COLS] = 16'h0004;
        glider[2*COLS +: COLS] = 16'h0007;

        reset         = 1'b1;
        abort         = 1'b0;
        rif.row_valid = 1'b0;
        rif.row_data  = '0;
        rif.row_last  = 1'b0;
        tick(2);
        chk("rst_ready", W'(rif.row_ready), W'(0));
        chk("rst_frame", frame_data, '0);
        chk("rst_load", W'(load), W'(0));
        chk("rst_err", W'(err), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_count", W'(frames_loaded), W'(0));
        reset = 1'b0;
        tick(1);
        chk("idle_ready", W'(rif.row_ready), W'(1));

        // Nominal diagonal frame.
        send_frame(diag, 1'b0);
        check_commit("nom", diag);
        tick(1);
        chk("nom_load_drop", W'(load), W'(0));
        chk("nom_count", W'(frames_loaded), W'(1));
        chk("nom_idle", W'(busy), W'(0));

        // Same frame with gaps between beats.
        send_frame(diag, 1'b1);
        check_commit("gap", diag);
        tick(1);
        chk("gap_count", W'(frames_loaded), W'(2));

        // Back-to-back frames.
        send_frame(diag, 1'b0);
        send_frame(anti, 1'b0);
        check_commit("b2b", anti);
        tick(1);
        chk("b2b_count", W'(frames_loaded), W'(4));

        // Early terminator on beat 5.
        for (int r = 0; r < 6; r++) send_beat(16'hffff, r == 5);
        chk("early_err", W'(err), W'(1));
        chk("early_load", W'(load), W'(0));
        chk("early_busy", W'(busy), W'(0));
        chk("early_data", frame_data, anti);
        tick(1);
        chk("early_err_drop", W'(err), W'(0));

        // Sixteen beats with no terminator.
        for (int r = 0; r < ROWS; r++) send_beat(16'h5555, 1'b0);
        chk("noterm_err", W'(err), W'(1));
        chk("noterm_busy", W'(busy), W'(0));
        chk("noterm_data", frame_data, anti);

        // Terminator on the very first beat.
        send_beat(16'h1234, 1'b1);
        chk("idle_last_err", W'(err), W'(1));
        chk("idle_last_busy", W'(busy), W'(0));
        tick(1);

        // Abort after beat 8 with a beat presented, then a glider.
        for (int r = 0; r < 9; r++) send_beat(16'haaaa, 1'b0);
        chk("pre_abort_busy", W'(busy), W'(1));
        abort         = 1'b1;
        rif.row_valid = 1'b1;
        rif.row_data  = 16'hffff;
        tick(1);
        abort         = 1'b0;
        rif.row_valid = 1'b0;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_err", W'(err), W'(0));
        send_frame(glider, 1'b0);
        check_commit("glider", glider);
        tick(1);
        chk("glider_count", W'(frames_loaded), W'(5));
        chk("load_total_a", W'(load_cnt), W'(5));
        chk("err_total", W'(err_cnt), W'(3));

        // Reset in the middle of a frame.
        for (int r = 0; r < 11; r++) send_beat(16'hf0f0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_frame", frame_data, '0);
        chk("midrst_count", W'(frames_loaded), W'(0));
        chk("midrst_ready", W'(rif.row_ready), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("midrst_noload", W'(load_cnt), W'(5));
        send_frame(anti, 1'b0);
        check_commit("postrst", anti);
        tick(1);
        chk("postrst_count", W'(frames_loaded), W'(1));

        // 256 back-to-back frames wrap the counter.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        wf = '0;
        for (int k = 0; k < 256; k++) begin
            for (int r = 0; r < ROWS; r++) begin
                wf[r*COLS +: COLS] = 16'(k * 37 + r * 5 + 1);
            end
            send_frame(wf, 1'b0);
        end
        chk("wrap_pre", W'(frames_loaded), W'(255));
        check_commit("wrap", wf);
        tick(1);
        chk("wrap_count", W'(frames_loaded), W'(0));
        chk("wrap_data", frame_data, wf);
        chk("load_total_b", W'(load_cnt), W'(262));
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/life_frame_loader.md
Name: life_frame_loader

Overview:
- Writer side of the life engine's load interface.
- Accepts a board as a stream of COLS-bit row words over a valid/ready handshake and assembles them in a private build buffer.
- On a correctly terminated frame, publishes the whole board on frame_data and pulses load for one cycle, so the engine latches a complete, stable frame.
- Malformed or aborted frames are dropped. frame_data never shows a partial board.

Parameters:
ROWS, 16, board rows; must be >= 2.
COLS, 16, board columns; ROWS*COLS = 256 for the standard engine.
CNT_W, 8, width of the frames_loaded counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
row_valid  input  1  row_data/row_last valid this cycle
row_data  input  COLS  one board row; bit j = column j
row_last  input  1  marks the final row of a frame
row_ready  output  1  loader can accept a beat this cycle
abort  input  1  synchronous discard of the frame in progress
frame_data  output  ROWS*COLS  last committed board; row r at bits [COLS*r +: COLS]
load  output  1  one-cycle pulse; frame_data is valid while high
busy  output  1  high in FILL or COMMIT
err  output  1  one-cycle pulse on a framing error
frames_loaded  output  CNT_W  count of committed frames

Behaviour:
- Reset values (asynchronous): state=IDLE, row_cnt=0, build buffer=0, frame_data=0, load=0, err=0, busy=0, frames_loaded=0. row_ready=0 while reset is asserted.
- Beat acceptance: a beat is accepted on a rising edge with row_valid & row_ready. row_data and row_last are ignored otherwise. Sender must hold row_valid, row_data and row_last until accepted.
- row_ready = 1 in IDLE and FILL; 0 in COMMIT and during reset.
- Accepted beat number r (0-based within the frame) is written to build[COLS*r +: COLS].
- IDLE:
  - Accepted beat with row_last=0 -> store as row 0, row_cnt=1, go to FILL.
  - Accepted beat with row_last=1 -> framing error: err pulse, stay in IDLE.
- FILL:
  - Accepted beat with row_cnt < ROWS-1 and row_last=0 -> store, row_cnt++.
  - Accepted beat with row_cnt < ROWS-1 and row_last=1 -> early terminator: err pulse, discard frame, go to IDLE.
  - Accepted beat with row_cnt = ROWS-1 and row_last=1 -> store, copy the full build buffer (including this row) into frame_data on the same edge, go to COMMIT.
  - Accepted beat with row_cnt = ROWS-1 and row_last=0 -> missing terminator: err pulse, discard frame, go to IDLE.
- COMMIT: lasts exactly one cycle.
  - load=1, frames_loaded++ (wraps from 2^CNT_W-1 to 0).
  - Unconditionally returns to IDLE, row_cnt=0.
- Latency: the final beat is accepted at edge N; frame_data updates and load rises at edge N. load is high for the cycle N..N+1.
- Minimum spacing: one frame per ROWS+1 cycles.
- frame_data changes only on entry to COMMIT and holds between commits, including across errors and aborts.
- Registering: load, err and frame_data are registered outputs. err and load are never high in the same cycle.
- abort: synchronous and highest priority.
  - In IDLE or FILL: go to IDLE, row_cnt=0, discard any beat presented that cycle, no err.
  - In COMMIT: ignored; the commit completes.
- Reset mid-frame: partial frame lost; frame_data returns to 0; no load is emitted.
- The build buffer is not cleared between frames. Every row is overwritten before a commit, so stale contents are never published.

Test Plan:
- Nominal frame: 16 beats, row r = 16'h0001<<r, row_last on beat 15 -> one load pulse the cycle after the last edge; frame_data has bit 17*r set for each r, all other bits 0; frames_loaded=1.
- Backpressure and gaps: same frame with row_valid dropped for 1–3 cycles between beats, plus back-to-back frames -> identical frame_data; loads spaced >= 17 cycles; row_ready=0 exactly in the COMMIT cycle.
- Framing errors:
  - row_last on beat 5 -> err pulse, no load, frame_data unchanged.
  - 16 beats with no row_last -> err on beat 15, no load.
  - row_last on the first beat in IDLE -> err, stays idle.
- Abort: abort asserted after beat 8, then a full glider frame -> no load for the aborted frame, no err; the glider commits correctly.
- Reset mid-frame: reset after beat 10 with a prior committed frame -> frame_data=0, frames_loaded=0, load never pulses; next full frame loads normally.
- Counter wrap: 256 consecutive valid frames -> frames_loaded reads 0 after the 256th load; frame_data equals the last frame.
